// File: rtl/ifetch_mem_responder.sv
// ---------------------------------------------------------------------------
// ifetch_mem_responder
//
// Memory-side responder for instruction-cache line fills on the shared
// 73-bit system bus. A single request beat addressed to MY_ID is latched,
// the 128-bit line is read from the backing bank, and the line is returned
// to the requester as two 64-bit beats once bus ownership is granted.
//
// Bus beat format: [72:69] dest, [68:65] src, [64] beat index, [63:0] payload.
// A request carries its byte address in payload[31:0].
//
// Ports:
//   clk           core clock
//   reset         asynchronous active-low reset
//   BUS           shared tristate bus, driven only while sending beats
//   DES_reciever  bus carries a valid request beat this cycle
//   DES_free      responder idle and able to accept a request
//   SER_req       bus ownership request for the response
//   SER_grant     bus ownership granted
//   SER_ack       destination accepted the beat currently driven
//   SER_release   one-cycle pulse when bus ownership is handed back
//   SER_dest      destination of the response (latched request src)
//   mem_rd_en     one-cycle memory read strobe
//   mem_addr      line address presented to the memory bank
//   mem_rd_data   line read data
//   mem_rd_valid  mem_rd_data valid (latency of one or more cycles)
//   resp_count    completed responses, wraps at 16 bits
//   err_unaligned sticky: a request address was not line aligned
//   err_overrun   sticky: a matching request arrived while busy
// ---------------------------------------------------------------------------
module ifetch_mem_responder #(
  parameter logic [3:0]  MY_ID  = 4'd1,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [72:0]       BUS,
  input  logic              DES_reciever,
  output logic              DES_free,
  output logic              SER_req,
  input  logic              SER_grant,
  input  logic              SER_ack,
  output logic              SER_release,
  output logic [3:0]        SER_dest,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [15:0]       resp_count,
  output logic              err_unaligned,
  output logic              err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ   = 3'd3,
    S_SEND0 = 3'd4,
    S_SEND1 = 3'd5,
    S_REL   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          src_q, src_d;
  logic [127:0]        line_q, line_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         resp_count_q, resp_count_d;
  logic                err_unaligned_q, err_unaligned_d;
  logic                err_overrun_q, err_overrun_d;

  // Output registers, loaded from the decode of the next state so they
  // line up with the state register without a combinational output path.
  logic                des_free_q, des_free_d;
  logic                ser_req_q, ser_req_d;
  logic                ser_release_q, ser_release_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic                bus_en_q, bus_en_d;
  logic [72:0]         bus_data_q, bus_data_d;

  logic                req_hit;
  logic                unused_bus_bits;

  // A request beat is only ours when the destination field matches.
  assign req_hit = DES_reciever && (BUS[72:69] == MY_ID);

  // Request payload bits above the line address carry nothing we use.
  assign unused_bus_bits = ^BUS[64:ADDR_W+4];

  // Release the bus whenever we are not sending a beat.
  assign BUS = bus_en_q ? bus_data_q : {73{1'bz}};

  assign DES_free      = des_free_q;
  assign SER_req       = ser_req_q;
  assign SER_release   = ser_release_q;
  assign SER_dest      = src_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_addr      = mem_addr_q;
  assign resp_count    = resp_count_q;
  assign err_unaligned = err_unaligned_q;
  assign err_overrun   = err_overrun_q;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      src_q           <= 4'd0;
      line_q          <= 128'd0;
      mem_addr_q      <= {ADDR_W{1'b0}};
      resp_count_q    <= 16'd0;
      err_unaligned_q <= 1'b0;
      err_overrun_q   <= 1'b0;
      des_free_q      <= 1'b1;
      ser_req_q       <= 1'b0;
      ser_release_q   <= 1'b0;
      mem_rd_en_q     <= 1'b0;
      bus_en_q        <= 1'b0;
      bus_data_q      <= 73'd0;
    end else begin
      state_q         <= state_d;
      src_q           <= src_d;
      line_q          <= line_d;
      mem_addr_q      <= mem_addr_d;
      resp_count_q    <= resp_count_d;
      err_unaligned_q <= err_unaligned_d;
      err_overrun_q   <= err_overrun_d;
      des_free_q      <= des_free_d;
      ser_req_q       <= ser_req_d;
      ser_release_q   <= ser_release_d;
      mem_rd_en_q     <= mem_rd_en_d;
      bus_en_q        <= bus_en_d;
      bus_data_q      <= bus_data_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    line_d          = line_q;
    mem_addr_d      = mem_addr_q;
    resp_count_d    = resp_count_q;
    err_unaligned_d = err_unaligned_q;
    err_overrun_d   = err_overrun_q;

    case (state_q)
      S_IDLE: begin
        if (req_hit) begin
          src_d      = BUS[68:65];
          // Low nibble is dropped: the line is served aligned regardless.
          mem_addr_d = BUS[ADDR_W+3:4];
          if (BUS[3:0] != 4'd0) begin
            err_unaligned_d = 1'b1;
          end else begin
            err_unaligned_d = err_unaligned_q;
          end
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          line_d  = mem_rd_data;
          state_d = S_REQ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_REQ: begin
        if (SER_grant) begin
          state_d = S_SEND0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_SEND0: begin
        if (SER_ack) begin
          state_d = S_SEND1;
        end else begin
          state_d = S_SEND0;
        end
      end
      S_SEND1: begin
        if (SER_ack) begin
          state_d = S_REL;
        end else begin
          state_d = S_SEND1;
        end
      end
      S_REL: begin
        resp_count_d = resp_count_q + 16'd1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request for us while busy is dropped but remembered.
    if ((state_q != S_IDLE) && req_hit) begin
      err_overrun_d = 1'b1;
    end else begin
      err_overrun_d = err_overrun_q;
    end
  end

  // Output decode of the state being entered.
  always_comb begin
    des_free_d    = 1'b0;
    ser_req_d     = 1'b0;
    ser_release_d = 1'b0;
    mem_rd_en_d   = 1'b0;
    bus_en_d      = 1'b0;
    bus_data_d    = 73'd0;

    case (state_d)
      S_IDLE: begin
        des_free_d = 1'b1;
      end
      S_READ: begin
        mem_rd_en_d = 1'b1;
      end
      S_WAIT: begin
        des_free_d = 1'b0;
      end
      S_REQ: begin
        ser_req_d = 1'b1;
      end
      S_SEND0: begin
        ser_req_d  = 1'b1;
        bus_en_d   = 1'b1;
        bus_data_d = {src_d, MY_ID, 1'b0, line_d[63:0]};
      end
      S_SEND1: begin
        ser_req_d  = 1'b1;
        bus_en_d   = 1'b1;
        bus_data_d = {src_d, MY_ID, 1'b1, line_d[127:64]};
      end
      S_REL: begin
        ser_release_d = 1'b1;
      end
      default: begin
        des_free_d = 1'b0;
      end
    endcase
  end

endmodule
